pip_stage_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the pip_en/discard pair of every

---
 rtl/pip_ctrl_pkg.sv | 19 +
 rtl/pip_hazard_detect.sv | 22 ++
 rtl/pip_stage_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pip_stage_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pip_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: FSM state
// encoding and the architectural zero register address.
package pip_ctrl_pkg;

    // Sequencer FSM state encoding
    localparam logic [1:0] RUN  = 2'b00;
    localparam logic [1:0] WAIT = 2'b01;
    localparam logic [1:0] ERR  = 2'b10;

    // Register x0 never carries a real dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control pair driven to one pipeline register
    typedef struct packed {
        logic pip_en;
        logic discard;
    } stage_ctrl_t;

endpackage

// File: rtl/pip_hazard_detect.sv
// Combinational load-use comparator: flags an ID-stage instruction that
// reads the destination of a load currently sitting in EX.
module pip_hazard_detect
    import pip_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_ad,
    input  logic [4:0] id_rs2_ad,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd_ad,
    input  logic       ex_DMread,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_rs1_used && (id_rs1_ad == ex_rd_ad);
    assign rs2_hit  = id_rs2_used && (id_rs2_ad == ex_rd_ad);
    assign load_use = ex_DMread && (ex_rd_ad != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pip_stage_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Drives pip_en /
// discard of IF/ID, ID/EX, EX/MEM, MEM/WB and the PC write enable with zero
// latency, and halts the pipeline when a data-memory access times out.
// Optional feature macro: PIP_PERF_CNT_EN adds stall_cnt / flush_cnt.
module pip_stage_ctrl
    import pip_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1_ad,
    input  logic [4:0] id_rs2_ad,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd_ad,
    input  logic       ex_DMread,
    input  logic       ex_br_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       pip_en_ifid,
    output logic       discard_ifid,
    output logic       pip_en_idex,
    output logic       discard_idex,
    output logic       pip_en_exmem,
    output logic       discard_exmem,
    output logic       pip_en_memwb,
    output logic       discard_memwb,
    output logic       mem_err
`ifdef PIP_PERF_CNT_EN
   ,output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_stall;
    logic             load_use;
    stage_ctrl_t      ctl_ifid;
    stage_ctrl_t      ctl_idex;
    stage_ctrl_t      ctl_exmem;
    stage_ctrl_t      ctl_memwb;

    // mem_ready without an outstanding request is meaningless and ignored
    assign mem_stall = mem_req && !mem_ready;

    pip_hazard_detect u_hazard (
        .id_rs1_ad   (id_rs1_ad),
        .id_rs2_ad   (id_rs2_ad),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd_ad    (ex_rd_ad),
        .ex_DMread   (ex_DMread),
        .load_use    (load_use)
    );

    // Output mux: reset bubbles, then ERR freeze, mem wait, branch flush, load-use
    always_comb begin
        pc_en     = 1'b1;
        ctl_ifid  = '{pip_en: 1'b1, discard: 1'b0};
        ctl_idex  = '{pip_en: 1'b1, discard: 1'b0};
        ctl_exmem = '{pip_en: 1'b1, discard: 1'b0};
        ctl_memwb = '{pip_en: 1'b1, discard: 1'b0};
        mem_err   = 1'b0;
        if (!rst_n) begin
            pc_en             = 1'b0;
            ctl_ifid.discard  = 1'b1;
            ctl_idex.discard  = 1'b1;
            ctl_exmem.discard = 1'b1;
            ctl_memwb.discard = 1'b1;
        end else if (state == ERR) begin
            pc_en            = 1'b0;
            ctl_ifid.pip_en  = 1'b0;
            ctl_idex.pip_en  = 1'b0;
            ctl_exmem.pip_en = 1'b0;
            ctl_memwb.pip_en = 1'b0;
            mem_err          = 1'b1;
        end else if (mem_stall) begin
            // Hold IF..MEM; WB gets a bubble. A pending flush or load-use
            // is still visible in EX after release and is handled then.
            pc_en             = 1'b0;
            ctl_ifid.pip_en   = 1'b0;
            ctl_idex.pip_en   = 1'b0;
            ctl_exmem.pip_en  = 1'b0;
            ctl_memwb.discard = 1'b1;
        end else if (ex_br_taken) begin
            // Squash the two wrong-path instructions, including any load-use victim
            ctl_ifid.discard = 1'b1;
            ctl_idex.discard = 1'b1;
        end else if (load_use) begin
            pc_en            = 1'b0;
            ctl_ifid.pip_en  = 1'b0;
            ctl_idex.discard = 1'b1;
        end
    end

    assign pip_en_ifid   = ctl_ifid.pip_en;
    assign discard_ifid  = ctl_ifid.discard;
    assign pip_en_idex   = ctl_idex.pip_en;
    assign discard_idex  = ctl_idex.discard;
    assign pip_en_exmem  = ctl_exmem.pip_en;
    assign discard_exmem = ctl_exmem.discard;
    assign pip_en_memwb  = ctl_memwb.pip_en;
    assign discard_memwb = ctl_memwb.discard;

    // Memory-wait FSM: counts stalled cycles and halts after MEM_TIMEOUT of them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!mem_stall) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef PIP_PERF_CNT_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = rst_n && (state != ERR) && !pc_en;
    assign flush_evt = rst_n && (state != ERR) && !mem_stall && ex_br_taken;

    // Performance counters: stall cycles and applied branch flushes, wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt) stall_cnt <= stall_cnt + 32'd1;
            if (flush_evt) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pip_stage_ctrl.sv
// Scoreboard bench for pip_stage_ctrl (MEM_TIMEOUT=4). Stimulus pushes the
// hand-computed control vector per cycle; a monitor pops and compares at the
// falling edge. Vector bit order:
// {pc_en, en_ifid, dis_ifid, en_idex, dis_idex, en_exmem, dis_exmem, en_memwb, dis_memwb, mem_err}
module tb_pip_stage_ctrl;

    localparam logic [9:0] V_RST = 10'b0_11_11_11_11_0;
    localparam logic [9:0] V_DEF = 10'b1_10_10_10_10_0;
    localparam logic [9:0] V_LU  = 10'b0_00_11_10_10_0;
    localparam logic [9:0] V_BR  = 10'b1_11_11_10_10_0;
    localparam logic [9:0] V_MS  = 10'b0_00_00_00_11_0;
    localparam logic [9:0] V_ERR = 10'b0_00_00_00_00_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1_ad, id_rs2_ad, ex_rd_ad;
    logic       id_rs1_used, id_rs2_used, ex_DMread, ex_br_taken, mem_req, mem_ready;
    logic       pc_en, pip_en_ifid, discard_ifid, pip_en_idex, discard_idex;
    logic       pip_en_exmem, discard_exmem, pip_en_memwb, discard_memwb, mem_err;
`ifdef PIP_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    logic [9:0] exp_q[$];
    string      nm_q[$];
    int         scnt_q[$];
    int         fcnt_q[$];
    int         nvec = 0;
    int         nmis = 0;

    always #5 clk = ~clk;

    pip_stage_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs1_ad     (id_rs1_ad),
        .id_rs2_ad     (id_rs2_ad),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .ex_rd_ad      (ex_rd_ad),
        .ex_DMread     (ex_DMread),
        .ex_br_taken   (ex_br_taken),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_en         (pc_en),
        .pip_en_ifid   (pip_en_ifid),
        .discard_ifid  (discard_ifid),
        .pip_en_idex   (pip_en_idex),
        .discard_idex  (discard_idex),
        .pip_en_exmem  (pip_en_exmem),
        .discard_exmem (discard_exmem),
        .pip_en_memwb  (pip_en_memwb),
        .discard_memwb (discard_memwb),
        .mem_err       (mem_err)
`ifdef PIP_PERF_CNT_EN
       ,.stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    // Drive one cycle of inputs and queue the expected response.
    // es/ef: expected perf counters at this cycle (-1 = not checked).
    task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic dm, input logic br, input logic mq, input logic mr,
                        input logic [9:0] e, input int es, input int ef, input string nm);
        @(posedge clk);
        #1;
        rst_n = r; id_rs1_ad = a1; id_rs2_ad = a2; id_rs1_used = u1; id_rs2_used = u2;
        ex_rd_ad = rd; ex_DMread = dm; ex_br_taken = br; mem_req = mq; mem_ready = mr;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        scnt_q.push_back(es);
        fcnt_q.push_back(ef);
    endtask

    // Monitor: compare the presented controls against the oldest expectation
    initial begin
        logic [9:0] got, ev;
        string      nm;
        int         es, ef;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                ev = exp_q.pop_front();
                nm = nm_q.pop_front();
                es = scnt_q.pop_front();
                ef = fcnt_q.pop_front();
                got = {pc_en, pip_en_ifid, discard_ifid, pip_en_idex, discard_idex,
                       pip_en_exmem, discard_exmem, pip_en_memwb, discard_memwb, mem_err};
                nvec++;
                if (got !== ev) begin
                    nmis++;
                    $display("FAIL %s: ctl got %b expected %b", nm, got, ev);
                end
`ifdef PIP_PERF_CNT_EN
                if (es >= 0) begin
                    nvec++;
                    if (stall_cnt !== es[31:0]) begin
                        nmis++;
                        $display("FAIL %s stall_cnt: got %0d expected %0d", nm, stall_cnt, es);
                    end
                end
                if (ef >= 0) begin
                    nvec++;
                    if (flush_cnt !== ef[31:0]) begin
                        nmis++;
                        $display("FAIL %s flush_cnt: got %0d expected %0d", nm, flush_cnt, ef);
                    end
                end
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b0; id_rs1_ad = '0; id_rs2_ad = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd_ad = '0; ex_DMread = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        //   r a1 a2 u1 u2 rd dm br mq mr
        // T1 reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_RST, -1, -1, "rst0");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_RST, -1, -1, "rst1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_DEF,  0,  0, "rst_release");
        // T2 load-use
        step(1, 0, 5, 0, 1, 5, 1, 0, 0, 0, V_LU,  -1, -1, "lu_rs2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_DEF,  1,  0, "lu_after");
        step(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, V_DEF, -1, -1, "lu_rd_zero");
        step(1, 7, 0, 1, 0, 7, 1, 0, 0, 0, V_LU,  -1, -1, "lu_rs1");
        step(1, 0, 5, 0, 0, 5, 1, 0, 0, 0, V_DEF, -1, -1, "lu_rs2_unused");
        step(1, 0, 5, 0, 1, 5, 0, 0, 0, 0, V_DEF, -1, -1, "lu_not_load");
        // T3 branch beats load-use
        step(1, 0, 5, 0, 1, 5, 1, 1, 0, 0, V_BR,  -1, -1, "br_over_lu");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_DEF,  2,  1, "br_after");
        // T4 three-cycle memory wait
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, V_MS,  -1, -1, "mw1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, V_MS,  -1, -1, "mw2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, V_MS,  -1, -1, "mw3");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, V_DEF, -1, -1, "mw_release");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, V_DEF,  5,  1, "ready_no_req");
        // stall beats branch; flush applied on release
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, V_MS,  -1, -1, "ms_over_br");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, V_BR,  -1, -1, "br_on_release");
        // stall holds a pending load-use, which resolves on release
        step(1, 0, 5, 0, 1, 5, 1, 0, 1, 0, V_MS,  -1, -1, "ms_over_lu");
        step(1, 0, 5, 0, 1, 5, 1, 0, 1, 1, V_LU,  -1, -1, "lu_on_release");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_DEF,  8,  2, "idle");
        // T5 timeout: 4 stalled cycles, then ERR freeze
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, V_MS,  -1, -1, "to1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, V_MS,  -1, -1, "to2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, V_MS,  -1, -1, "to3");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, V_MS,  -1, -1, "to4");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, V_ERR, 12,  2, "err1");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, V_ERR, -1, -1, "err_br");
        step(1, 0, 5, 0, 1, 5, 1, 0, 1, 1, V_ERR, 12,  2, "err_hold");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_RST, -1, -1, "err_rst0");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_RST, -1, -1, "err_rst1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_DEF,  0,  0, "post_rst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, V_MS,  -1, -1, "post_rst_ms");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, V_DEF, -1, -1, "post_rst_rel");

        // Drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            nvec++;
            nmis++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
